// File: rtl/ucsbece154b_bp_pkg.sv
// Shared encodings and slice helpers for the gshare fetch-stage branch predictor.
package ucsbece154b_bp_pkg;

  typedef enum logic [1:0] {
    bp_cond = 2'b00,
    bp_jump = 2'b01,
    bp_call = 2'b10,
    bp_ret  = 2'b11
  } bp_type_e;

  // Instructions are word aligned, so the two low PC bits carry no information.
  localparam int unsigned PC_ALIGN_BITS = 2;
  localparam int unsigned PC_WIDTH      = 32;

  function automatic int unsigned idx_bits(input int unsigned entries);
    return (entries > 1) ? $clog2(entries) : 1;
  endfunction

  function automatic int unsigned tag_lsb(input int unsigned entries);
    return PC_ALIGN_BITS + idx_bits(entries);
  endfunction

  // Weakly not-taken: one below the counter midpoint.
  function automatic int unsigned ctr_reset_val(input int unsigned ctr_bits);
    return (32'd1 << (ctr_bits - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/ucsbece154b_ras.sv
// Return address stack trained at Execute; a push when full overwrites the oldest entry.
module ucsbece154b_ras #(
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             reset_i,
  input  logic                             push_i,
  input  logic                             pop_i,
  input  logic [31:0]                      data_i,
  output logic [31:0]                      top_o,
  output logic                             empty_o,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  logic [31:0]      r_mem [RAS_DEPTH];
  logic [PTR_W-1:0] r_sp;       // next slot to write
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] w_top_ptr;
  logic [PTR_W-1:0] w_sp_inc;
  logic             w_do_pop;

  assign w_top_ptr = (r_sp == '0) ? PTR_LAST : r_sp - 1'b1;
  assign w_sp_inc  = (r_sp == PTR_LAST) ? '0 : r_sp + 1'b1;
  assign w_do_pop  = pop_i && !push_i && (r_count != '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      r_sp    <= '0;
      r_count <= '0;
    end else if (push_i) begin
      r_sp <= w_sp_inc;
      if (r_count != CNT_FULL) r_count <= r_count + 1'b1;
    end else if (w_do_pop) begin
      r_sp    <= w_top_ptr;
      r_count <= r_count - 1'b1;
    end
  end

  // NOTE: storage arrays carry no reset; r_count marks which slots are live,
  // so clearing the data would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (push_i) r_mem[r_sp] <= data_i;
  end

  assign top_o   = r_mem[w_top_ptr];
  assign empty_o = (r_count == '0);
  assign count_o = r_count;

endmodule

// File: rtl/ucsbece154b_gshare_predictor.sv
// Fetch-stage predictor: tagged BTB with type, gshare PHT, checkpointed GHR and RAS.
module ucsbece154b_gshare_predictor
  import ucsbece154b_bp_pkg::*;
#(
  parameter int unsigned NUM_BTB_ENTRIES = 16,
  parameter int unsigned NUM_GHR_BITS    = 4,
  parameter int unsigned TAG_BITS        = 8,
  parameter int unsigned CTR_BITS        = 2,
  parameter int unsigned RAS_DEPTH       = 4
) (
  input  logic                    clk,
  input  logic                    reset_i,
  input  logic [31:0]             pc_i,
  input  logic                    stall_i,
  output logic                    BranchTaken_o,
  output logic [31:0]             BTBtarget_o,
  output logic [NUM_GHR_BITS-1:0] PHTindex_o,
  output logic [NUM_GHR_BITS-1:0] GHRsnap_o,
  input  logic                    upd_valid_i,
  input  logic [31:0]             upd_pc_i,
  input  logic [1:0]              upd_type_i,
  input  logic                    upd_taken_i,
  input  logic [31:0]             upd_target_i,
  input  logic [NUM_GHR_BITS-1:0] upd_phtindex_i,
  input  logic [NUM_GHR_BITS-1:0] upd_ghr_i,
  input  logic                    upd_mispredict_i
);

  localparam int unsigned IDX_W       = idx_bits(NUM_BTB_ENTRIES);
  localparam int unsigned TAG_LSB     = tag_lsb(NUM_BTB_ENTRIES);
  localparam int unsigned PHT_ENTRIES = 1 << NUM_GHR_BITS;
  localparam logic [CTR_BITS-1:0] CTR_RST = CTR_BITS'(ctr_reset_val(CTR_BITS));
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam int unsigned RAS_CNT_W   = $clog2(RAS_DEPTH + 1);

  logic                r_btb_valid  [NUM_BTB_ENTRIES];
  logic [TAG_BITS-1:0] r_btb_tag    [NUM_BTB_ENTRIES];
  logic [31:0]         r_btb_target [NUM_BTB_ENTRIES];
  bp_type_e            r_btb_type   [NUM_BTB_ENTRIES];
  logic [CTR_BITS-1:0] r_pht        [PHT_ENTRIES];
  logic [NUM_GHR_BITS-1:0] r_ghr;

  logic [IDX_W-1:0]        w_f_idx;
  logic [TAG_BITS-1:0]     w_f_tag;
  logic                    w_f_hit;
  bp_type_e                w_f_type;
  logic [NUM_GHR_BITS-1:0] w_pht_idx;
  logic                    w_pred_dir;

  logic [IDX_W-1:0]    w_u_idx;
  logic [TAG_BITS-1:0] w_u_tag;
  bp_type_e            w_u_type;
  logic                w_u_cond;
  logic                w_btb_we;

  logic                 w_ras_push;
  logic                 w_ras_pop;
  logic [31:0]          w_ras_top;
  logic                 w_ras_empty;
  logic [RAS_CNT_W-1:0] w_ras_count;
  logic                 w_unused;

  // Fetch-side lookup, all from pre-edge state.
  assign w_f_idx    = pc_i[TAG_LSB-1:PC_ALIGN_BITS];
  assign w_f_tag    = pc_i[TAG_LSB+TAG_BITS-1:TAG_LSB];
  assign w_f_hit    = r_btb_valid[w_f_idx] && (r_btb_tag[w_f_idx] == w_f_tag);
  assign w_f_type   = r_btb_type[w_f_idx];
  assign w_pht_idx  = r_ghr ^ pc_i[NUM_GHR_BITS+1:PC_ALIGN_BITS];
  assign w_pred_dir = r_pht[w_pht_idx][CTR_BITS-1];

  assign BranchTaken_o = w_f_hit && ((w_f_type != bp_cond) || w_pred_dir);
  assign PHTindex_o    = w_pht_idx;
  assign GHRsnap_o     = r_ghr;

  always_comb begin
    // NOTE: default first so every path assigns the output and no latch is inferred.
    BTBtarget_o = 32'b0;
    if (w_f_hit) begin
      if ((w_f_type == bp_ret) && !w_ras_empty) BTBtarget_o = w_ras_top;
      else                                      BTBtarget_o = r_btb_target[w_f_idx];
    end
  end

  // Execute-side training decode.
  assign w_u_idx  = upd_pc_i[TAG_LSB-1:PC_ALIGN_BITS];
  assign w_u_tag  = upd_pc_i[TAG_LSB+TAG_BITS-1:TAG_LSB];
  assign w_u_type = bp_type_e'(upd_type_i);
  assign w_u_cond = (w_u_type == bp_cond);
  // A not-taken conditional never allocates, so a live entry survives it.
  assign w_btb_we = upd_valid_i && (upd_taken_i || !w_u_cond);

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < NUM_BTB_ENTRIES; i++) r_btb_valid[i] <= 1'b0;
    end else if (w_btb_we) begin
      r_btb_valid[w_u_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_btb_we) begin
      r_btb_tag[w_u_idx]    <= w_u_tag;
      r_btb_target[w_u_idx] <= upd_target_i;
      r_btb_type[w_u_idx]   <= w_u_type;
    end
  end

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < PHT_ENTRIES; i++) r_pht[i] <= CTR_RST;
    end else if (upd_valid_i && w_u_cond) begin
      if (upd_taken_i) begin
        if (r_pht[upd_phtindex_i] != CTR_MAX)
          r_pht[upd_phtindex_i] <= r_pht[upd_phtindex_i] + 1'b1;
      end else if (r_pht[upd_phtindex_i] != '0) begin
        r_pht[upd_phtindex_i] <= r_pht[upd_phtindex_i] - 1'b1;
      end
    end
  end

  // Recovery from the checkpoint outranks the speculative fetch shift.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      r_ghr <= '0;
    end else if (upd_valid_i && upd_mispredict_i) begin
      r_ghr <= w_u_cond ? {upd_ghr_i[NUM_GHR_BITS-2:0], upd_taken_i} : upd_ghr_i;
    end else if (!stall_i && w_f_hit && (w_f_type == bp_cond)) begin
      r_ghr <= {r_ghr[NUM_GHR_BITS-2:0], w_pred_dir};
    end
  end

  assign w_ras_push = upd_valid_i && (w_u_type == bp_call);
  assign w_ras_pop  = upd_valid_i && (w_u_type == bp_ret);

  ucsbece154b_ras #(
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .reset_i (reset_i),
    .push_i  (w_ras_push),
    .pop_i   (w_ras_pop),
    .data_i  (upd_pc_i + 32'd4),
    .top_o   (w_ras_top),
    .empty_o (w_ras_empty),
    .count_o (w_ras_count)
  );

  assign w_unused = ^{pc_i, w_ras_count};

endmodule

// File: tb/tb_ucsbece154b_gshare_predictor.sv
// Self-checking bench: directed vector table, hand sequences, and random traffic vs a queue/array model.
module tb_ucsbece154b_gshare_predictor;

  localparam int NB    = 16;
  localparam int NG    = 4;
  localparam int TB    = 8;
  localparam int CB    = 2;
  localparam int RD    = 4;
  localparam int IB    = 4;
  localparam int PHT_N = 1 << NG;
  localparam int T_C = 0, T_J = 1, T_CL = 2, T_R = 3;

  logic          clk = 1'b0;
  logic          reset_i;
  logic [31:0]   pc_i;
  logic          stall_i;
  logic          BranchTaken_o;
  logic [31:0]   BTBtarget_o;
  logic [NG-1:0] PHTindex_o;
  logic [NG-1:0] GHRsnap_o;
  logic          upd_valid_i;
  logic [31:0]   upd_pc_i;
  logic [1:0]    upd_type_i;
  logic          upd_taken_i;
  logic [31:0]   upd_target_i;
  logic [NG-1:0] upd_phtindex_i;
  logic [NG-1:0] upd_ghr_i;
  logic          upd_mispredict_i;

  always #5 clk = ~clk;

  ucsbece154b_gshare_predictor #(
    .NUM_BTB_ENTRIES (NB), .NUM_GHR_BITS (NG), .TAG_BITS (TB), .CTR_BITS (CB), .RAS_DEPTH (RD)
  ) dut (
    .clk (clk), .reset_i (reset_i), .pc_i (pc_i), .stall_i (stall_i),
    .BranchTaken_o (BranchTaken_o), .BTBtarget_o (BTBtarget_o),
    .PHTindex_o (PHTindex_o), .GHRsnap_o (GHRsnap_o),
    .upd_valid_i (upd_valid_i), .upd_pc_i (upd_pc_i), .upd_type_i (upd_type_i),
    .upd_taken_i (upd_taken_i), .upd_target_i (upd_target_i),
    .upd_phtindex_i (upd_phtindex_i), .upd_ghr_i (upd_ghr_i),
    .upd_mispredict_i (upd_mispredict_i)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] pc;   logic stall;
    logic uv; logic [1:0] ut; logic utk; logic [31:0] utgt; logic [31:0] upc;
    logic [NG-1:0] upi; logic [NG-1:0] ug; logic ump;
    logic etk; logic [31:0] etgt; logic [NG-1:0] epi; logic [NG-1:0] egs;
  } vec_t;

  function automatic vec_t mk(input int pc, input int st, input int uv, input int ut, input int tk,
                              input int tgt, input int upc, input int upi, input int ug, input int mp,
                              input int etk, input int etgt, input int epi, input int egs);
    vec_t v;
    v.pc = pc; v.stall = st[0]; v.uv = uv[0]; v.ut = ut[1:0]; v.utk = tk[0];
    v.utgt = tgt; v.upc = upc; v.upi = upi[NG-1:0]; v.ug = ug[NG-1:0]; v.ump = mp[0];
    v.etk = etk[0]; v.etgt = etgt; v.epi = epi[NG-1:0]; v.egs = egs[NG-1:0];
    return v;
  endfunction

  // Reference model: plain arrays plus a queue for the return stack.
  bit          m_valid [NB];
  int unsigned m_tag   [NB];
  int unsigned m_tgt   [NB];
  int unsigned m_type  [NB];
  int unsigned m_pht   [PHT_N];
  int unsigned m_ghr;
  int unsigned m_ras   [$];

  function automatic void model_reset();
    for (int i = 0; i < NB; i++) m_valid[i] = 1'b0;
    for (int i = 0; i < PHT_N; i++) m_pht[i] = (1 << (CB - 1)) - 1;
    m_ghr = 0;
    m_ras.delete();
  endfunction

  function automatic void model_predict(input int unsigned pc, output bit hit, output int unsigned typ,
                                        output bit dir, output bit tk, output int unsigned tgt,
                                        output int unsigned pi);
    int unsigned idx, tag;
    idx = (pc >> 2) % NB;
    tag = (pc >> (2 + IB)) % (1 << TB);
    hit = m_valid[idx] && (m_tag[idx] == tag);
    typ = m_type[idx];
    pi  = (m_ghr ^ (pc >> 2)) % PHT_N;
    dir = (m_pht[pi] >= (1 << (CB - 1)));
    tk  = hit && (typ != T_C || dir);
    if (!hit)                                  tgt = 0;
    else if (typ == T_R && m_ras.size() > 0)   tgt = m_ras[$];
    else                                       tgt = m_tgt[idx];
  endfunction

  function automatic void model_step(input vec_t v);
    bit hit, dir, tk;
    int unsigned typ, tgt, pi, uidx;
    model_predict(v.pc, hit, typ, dir, tk, tgt, pi);
    if (v.uv && v.ump)
      m_ghr = (v.ut == T_C) ? (((int'(v.ug) << 1) | int'(v.utk)) % PHT_N) : int'(v.ug);
    else if (!v.stall && hit && typ == T_C)
      m_ghr = ((m_ghr << 1) | dir) % PHT_N;
    if (v.uv && v.ut == T_C) begin
      if (v.utk && m_pht[v.upi] < (1 << CB) - 1) m_pht[v.upi]++;
      else if (!v.utk && m_pht[v.upi] > 0)       m_pht[v.upi]--;
    end
    if (v.uv && (v.utk || v.ut != T_C)) begin
      uidx = (v.upc >> 2) % NB;
      m_valid[uidx] = 1'b1;
      m_tag[uidx]   = (v.upc >> (2 + IB)) % (1 << TB);
      m_tgt[uidx]   = v.utgt;
      m_type[uidx]  = v.ut;
    end
    if (v.uv && v.ut == T_CL) begin
      m_ras.push_back(v.upc + 4);
      if (m_ras.size() > RD) void'(m_ras.pop_front());
    end else if (v.uv && v.ut == T_R && m_ras.size() > 0) begin
      void'(m_ras.pop_back());
    end
  endfunction

  task automatic drive(input vec_t v);
    pc_i = v.pc; stall_i = v.stall; upd_valid_i = v.uv; upd_type_i = v.ut;
    upd_taken_i = v.utk; upd_target_i = v.utgt; upd_pc_i = v.upc;
    upd_phtindex_i = v.upi; upd_ghr_i = v.ug; upd_mispredict_i = v.ump;
  endtask

  // One fetch cycle: drive at negedge, sample 1ns later, let the edge commit, advance the model.
  task automatic do_cycle(input vec_t v, output logic tk, output logic [31:0] tgt,
                          output logic [NG-1:0] pi, output logic [NG-1:0] gs);
    @(negedge clk);
    drive(v);
    #1;
    tk = BranchTaken_o; tgt = BTBtarget_o; pi = PHTindex_o; gs = GHRsnap_o;
    @(posedge clk);
    model_step(v);
  endtask

  task automatic run_vec(input string name, input vec_t v);
    logic tk; logic [31:0] tgt; logic [NG-1:0] pi, gs;
    do_cycle(v, tk, tgt, pi, gs);
    check({name, "_taken"}, {31'b0, tk}, {31'b0, v.etk});
    check({name, "_target"}, tgt, v.etgt);
    check({name, "_phtidx"}, {28'b0, pi}, {28'b0, v.epi});
    check({name, "_ghr"}, {28'b0, gs}, {28'b0, v.egs});
  endtask

  vec_t vecs[$];
  vec_t idle;

  initial begin
    logic tk; logic [31:0] tgt; logic [NG-1:0] pi, gs;
    bit m_hit, m_dir, m_tk; int unsigned m_typ, m_tgt_v, m_pi;
    vec_t v;

    // pc, stall, uv, type, taken, tgt, upc, upi, ughr, mp || exp taken, target, phtidx, ghrsnap
    vecs.push_back(mk('h100,0, 0,0,   0,0,    0,    0,0,  0, 0,0,    0,0));
    vecs.push_back(mk('h100,0, 1,T_C, 1,'h80, 'h100,0,0,  0, 0,0,    0,0));
    vecs.push_back(mk('h100,1, 1,T_C, 1,'h80, 'h100,0,0,  0, 1,'h80, 0,0));
    vecs.push_back(mk('h100,1, 1,T_C, 1,'h80, 'h100,0,0,  0, 1,'h80, 0,0));
    vecs.push_back(mk('h100,1, 1,T_C, 0,'h80, 'h100,0,0,  0, 1,'h80, 0,0));
    vecs.push_back(mk('h100,1, 1,T_C, 0,'h80, 'h100,0,0,  0, 1,'h80, 0,0));
    vecs.push_back(mk('h100,0, 0,0,   0,0,    0,    0,0,  0, 0,'h80, 0,0));
    vecs.push_back(mk('h100,1, 1,T_C, 1,'h80, 'h100,3,0,  0, 0,'h80, 0,0));
    vecs.push_back(mk('h100,1, 1,T_J, 1,'h500,'h3C, 0,3,  1, 0,'h80, 0,0));
    vecs.push_back(mk('h100,0, 0,0,   0,0,    0,    0,0,  0, 1,'h80, 3,3));
    vecs.push_back(mk('h100,1, 0,0,   0,0,    0,    0,0,  0, 0,'h80, 7,7));
    vecs.push_back(mk('h100,1, 1,T_J, 1,'h500,'h3C, 0,3,  1, 0,'h80, 7,7));
    vecs.push_back(mk('h100,0, 1,T_C, 0,'h80, 'h100,5,'hA,1, 1,'h80, 3,3));
    vecs.push_back(mk('h100,1, 0,0,   0,0,    0,    0,0,  0, 0,'h80, 4,4));
    vecs.push_back(mk('h3C, 0, 0,0,   0,0,    0,    0,0,  0, 1,'h500,'hB,4));
    vecs.push_back(mk('h3C, 0, 0,0,   0,0,    0,    0,0,  0, 1,'h500,'hB,4));
    vecs.push_back(mk('h100,1, 1,T_CL,1,'h600,'h200,0,0,  0, 0,'h80, 4,4));
    vecs.push_back(mk('h100,1, 1,T_CL,1,'h600,'h200,0,0,  0, 0,0,    4,4));
    vecs.push_back(mk('h300,1, 1,T_R, 1,'h700,'h300,0,0,  0, 0,0,    4,4));
    vecs.push_back(mk('h300,0, 0,0,   0,0,    0,    0,0,  0, 1,'h204, 4,4));
    vecs.push_back(mk('h300,1, 1,T_R, 1,'h700,'h300,0,0,  0, 1,'h204, 4,4));
    vecs.push_back(mk('h300,1, 0,0,   0,0,    0,    0,0,  0, 1,'h700, 4,4));
    vecs.push_back(mk('h300,1, 1,T_R, 1,'h700,'h300,0,0,  0, 1,'h700, 4,4));
    vecs.push_back(mk('h300,1, 1,T_CL,1,'h600,'h210,0,0,  0, 1,'h700, 4,4));
    vecs.push_back(mk('h300,1, 0,0,   0,0,    0,    0,0,  0, 1,'h214, 4,4));
    vecs.push_back(mk('h100,1, 1,T_C, 1,'h80, 'h100,0,0,  0, 0,0,    4,4));
    vecs.push_back(mk('h100,1, 1,T_J, 1,'h900,'h140,0,0,  0, 0,'h80, 4,4));
    vecs.push_back(mk('h100,1, 0,0,   0,0,    0,    0,0,  0, 0,0,    4,4));
    vecs.push_back(mk('h140,1, 0,0,   0,0,    0,    0,0,  0, 1,'h900, 4,4));

    idle = mk('h100,0, 0,0,0,0,0,0,0,0, 0,0,0,0);

    // Reset state.
    reset_i = 1'b0;
    drive(idle);
    model_reset();
    #1;
    check("rst_taken",  {31'b0, BranchTaken_o}, 32'd0);
    check("rst_target", BTBtarget_o, 32'd0);
    check("rst_ghr",    {28'b0, GHRsnap_o}, 32'd0);
    check("rst_phtidx", {28'b0, PHTindex_o}, 32'd0);
    pc_i = 32'h134;
    #1;
    check("rst_phtidx_pc", {28'b0, PHTindex_o}, 32'hD);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_i = 1'b1;

    foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Asynchronous reset landing mid-cycle with an update in flight.
    @(negedge clk);
    drive(mk('h140,0, 1,T_CL,1,'h600,'h20,0,0,0, 0,0,0,0));
    #2;
    reset_i = 1'b0;
    #1;
    check("midrst_taken",  {31'b0, BranchTaken_o}, 32'd0);
    check("midrst_target", BTBtarget_o, 32'd0);
    check("midrst_ghr",    {28'b0, GHRsnap_o}, 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    drive(mk('h140,1, 0,0,0,0,0,0,0,0, 0,0,0,0));
    reset_i = 1'b1;
    #1;
    check("postrst_taken",  {31'b0, BranchTaken_o}, 32'd0);
    check("postrst_target", BTBtarget_o, 32'd0);

    // Five calls into a four-deep stack, then drain through a return entry at 0x33C.
    run_vec("ras_alloc", mk('h33C,1, 1,T_R,1,'h777,'h33C,0,0,0, 0,0,'hF,0));
    for (int i = 1; i <= 5; i++) begin
      int unsigned exp_t;
      exp_t = (i == 1) ? 'h777 : (16 * (i - 1) + 4);
      run_vec($sformatf("ras_call%0d", i), mk('h33C,1, 1,T_CL,1,'h1000,16*i,0,0,0, 1,exp_t,'hF,0));
    end
    run_vec("ras_full",  mk('h33C,1, 0,0,0,0,0,0,0,0,           1,'h54, 'hF,0));
    run_vec("ras_pop1",  mk('h33C,1, 1,T_R,1,'h777,'h33C,0,0,0, 1,'h54, 'hF,0));
    run_vec("ras_pop2",  mk('h33C,1, 1,T_R,1,'h777,'h33C,0,0,0, 1,'h44, 'hF,0));
    run_vec("ras_pop3",  mk('h33C,1, 1,T_R,1,'h777,'h33C,0,0,0, 1,'h34, 'hF,0));
    run_vec("ras_pop4",  mk('h33C,1, 1,T_R,1,'h777,'h33C,0,0,0, 1,'h24, 'hF,0));
    run_vec("ras_empty", mk('h33C,1, 0,0,0,0,0,0,0,0,           1,'h777,'hF,0));
    run_vec("ras_pop_e", mk('h33C,1, 1,T_R,1,'h777,'h33C,0,0,0, 1,'h777,'hF,0));
    run_vec("ras_push1", mk('h33C,1, 1,T_CL,1,'h1000,'h60,0,0,0,1,'h777,'hF,0));
    run_vec("ras_one",   mk('h33C,1, 0,0,0,0,0,0,0,0,           1,'h64, 'hF,0));

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      int t, tkn;
      t   = $urandom_range(0, 3);
      tkn = (t == T_C) ? $urandom_range(0, 1) : 1;
      v = mk($urandom_range(0, 255) << 2, ($urandom_range(0, 3) == 0) ? 1 : 0,
             $urandom_range(0, 1), t, tkn, $urandom_range(0, 'hFFFF) << 2,
             $urandom_range(0, 255) << 2, $urandom_range(0, PHT_N - 1),
             $urandom_range(0, PHT_N - 1), ($urandom_range(0, 3) == 0) ? 1 : 0, 0, 0, 0, 0);
      model_predict(v.pc, m_hit, m_typ, m_dir, m_tk, m_tgt_v, m_pi);
      gs = m_ghr[NG-1:0];
      do_cycle(v, tk, tgt, pi, gs);
      check($sformatf("rnd%0d_taken", i),  {31'b0, tk}, {31'b0, m_tk});
      check($sformatf("rnd%0d_target", i), tgt, m_tgt_v);
      check($sformatf("rnd%0d_phtidx", i), {28'b0, pi}, m_pi);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(mk($urandom_range(0, 255) << 2, 1, 0,0,0,0,0,0,0,0, 0,0,0,0));
      #1;
      check($sformatf("rnd_ghr%0d", i), {28'b0, GHRsnap_o}, m_ghr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ucsbece154b_gshare_predictor.md
Name: ucsbece154b_gshare_predictor

Overview:
Parametrised next-generation fetch-stage branch predictor for the 5-stage RV32I pipeline. It combines a tagged, direct-mapped BTB with per-entry control-flow type, a gshare PHT of saturating counters indexed by the GHR XOR PC bits, a speculatively updated GHR with checkpoint recovery, and a return address stack (RAS). Prediction is combinational from the fetch PC. All training comes from one Execute-stage update port per cycle.

Parameters:
NUM_BTB_ENTRIES, 16, BTB depth; power of two, at least 2
NUM_GHR_BITS, 4, GHR width; the PHT has 2^NUM_GHR_BITS entries
TAG_BITS, 8, BTB tag width, taken from pc above the index bits
CTR_BITS, 2, PHT counter width, 2..4
RAS_DEPTH, 4, RAS entries; power of two

Ports:
clk  in  1  clock; all state is rising-edge
reset_i  in  1  asynchronous, active-low reset
pc_i  in  32  fetch PC (PCF)
stall_i  in  1  fetch stall; blocks the speculative GHR shift
BranchTaken_o  out  1  predict redirect this cycle
BTBtarget_o  out  32  predicted target
PHTindex_o  out  NUM_GHR_BITS  PHT index used; carried down the pipe
GHRsnap_o  out  NUM_GHR_BITS  GHR value before this fetch's shift; carried down the pipe
upd_valid_i  in  1  Execute-stage control-flow instruction resolved
upd_pc_i  in  32  PC of the resolved instruction
upd_type_i  in  2  00 cond, 01 jump, 10 call, 11 return
upd_taken_i  in  1  actual direction (1 for all non-cond types)
upd_target_i  in  32  actual target
upd_phtindex_i  in  NUM_GHR_BITS  PHTindex_o carried with the instruction
upd_ghr_i  in  NUM_GHR_BITS  GHRsnap_o carried with the instruction
upd_mispredict_i  in  1  direction or target was wrong; pipeline is flushing

Behaviour:
- Index: idx = pc[log2(NUM_BTB_ENTRIES)+1:2]. Tag: the TAG_BITS bits directly above idx. hit = valid[idx] && tag match.
- PHTindex_o = GHR XOR pc[NUM_GHR_BITS+1:2]. GHRsnap_o = GHR.
- BranchTaken_o = hit && (type != cond || counter MSB == 1).
- BTBtarget_o selection:
  - type == return and RAS non-empty: RAS top.
  - otherwise on hit: stored target.
  - miss: 32'b0.
- Prediction reads pre-edge state; a same-cycle update is not visible until the next cycle. There is no write bypass.
- GHR update priority:
  1. upd_valid_i && upd_mispredict_i: GHR <= cond ? {upd_ghr_i[N-2:0], upd_taken_i} : upd_ghr_i.
  2. Else !stall_i && hit && type == cond: GHR <= {GHR[N-2:0], predicted direction}.
  3. Else hold.
  Priority 1 overrides the fetch shift in the same cycle.
- PHT: on upd_valid_i && cond, the counter at upd_phtindex_i is incremented when taken and decremented when not taken. It saturates at 0 and at 2^CTR_BITS-1.
- BTB write: on upd_valid_i && (upd_taken_i || type != cond), write entry upd_pc_i idx with valid=1, tag, upd_target_i and type. This replaces any conflicting entry. A not-taken cond does not allocate and leaves an existing entry untouched.
- RAS (non-speculative, trained at update):
  - call: push upd_pc_i+4. When full, overwrite the oldest entry (circular wrap); the count stays at RAS_DEPTH.
  - return: pop. Pop when empty is a no-op.
  - On a return update, the BTB target is still written as normal.
- Reset (asynchronous, may assert mid-operation): all BTB valid=0, GHR=0, all counters = 2^(CTR_BITS-1)-1 (weakly not-taken), RAS empty.
  - Post-reset outputs: BranchTaken_o=0, BTBtarget_o=0, GHRsnap_o=0, PHTindex_o=pc_i[NUM_GHR_BITS+1:2].
  - Partial updates in flight at reset are discarded.
- Latency: prediction is 0 cycles (combinational). Training is visible 1 cycle after the update edge.

Decomposition:
- Package ucsbece154b_bp_pkg:
  - type encodings (bp_cond, bp_jump, bp_call, bp_ret)
  - counter reset-value function
  - idx/tag slice width localparams
- Sub-module ucsbece154b_ras with parameter RAS_DEPTH:
  - inputs: push, pop, push data
  - outputs: top, empty, count
  - the circular pointer and saturating count are instantiated once.

Test Plan:
- Reset, then pc_i=0x100 -> BranchTaken_o=0, BTBtarget_o=0, GHRsnap_o=0. Release reset; all entries miss.
- Update cond at 0x100, taken, target 0x80, twice -> a fetch at 0x100 (GHR as checkpointed) gives BranchTaken_o=1 and BTBtarget_o=0x80. The counter at the index goes 01->10->11 and saturates on a third taken update.
- Fetch cond hit, predicted taken, with GHR=4'b0011 -> next GHR=4'b0111. In the same cycle, a mispredict update with upd_ghr_i=4'b1010 and taken=0 -> GHR=4'b0100 (recovery wins).
- Call at 0x200 updated, then return at 0x300 allocated -> fetch at 0x300 predicts taken with target 0x204. After the return update the RAS is empty and the target falls back to the BTB entry.
- Five calls with RAS_DEPTH=4 (from 0x10,0x20,0x30,0x40,0x50) -> pops yield 0x54,0x44,0x34,0x24, then empty. A pop on empty leaves the count at 0.
- Aliasing: entries at 0x100 and 0x100+4*NUM_BTB_ENTRIES with differing tags -> the second write evicts the first, and a fetch at 0x100 misses (BranchTaken_o=0).
